prim_iter_math: RTL and testbench

//  Sequential, width-parametrised hardware counterpart of the constant-time math helpers: floor/ceil

---
 rtl/prim_iter_math_pkg.sv | 25 ++
 rtl/prim_iter_math_lzc.sv | 19 +
 rtl/prim_iter_math.sv | 168 ++++++++++++++++
 tb/tb_prim_iter_math.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_iter_math_pkg.sv
// Shared types for the iterative math unit: opcode and FSM state encodings.
package prim_iter_math_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef enum logic [1:0] {
    OpDiv     = 2'd0,
    OpCeilDiv = 2'd1,
    OpClog2   = 2'd2,
    OpVbits   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StDiv  = 3'd1,
    StFix  = 3'd2,
    StLog  = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic logic is_div_op(op_e op);
    return (op == OpDiv) || (op == OpCeilDiv);
  endfunction

endpackage

// File: rtl/prim_iter_math_lzc.sv
// Combinational leading-zero count of the dividend, used to shorten the divide loop.
// Only instantiated when PRIM_ITER_MATH_EARLY_EXIT_EN is defined.
module prim_iter_math_lzc #(
  parameter int unsigned Width = 16,
  localparam int unsigned CntW = $clog2(Width + 1)
) (
  input  logic [Width-1:0] a_i,
  output logic [CntW-1:0]  lz_cnt_o
);

  // Scanning LSB to MSB lets the highest set bit win; a == 0 yields Width.
  always_comb begin
    lz_cnt_o = CntW'(Width);
    for (int i = 0; i < int'(Width); i++) begin
      if (a_i[i]) lz_cnt_o = CntW'(int'(Width) - 1 - i);
    end
  end

endmodule

// File: rtl/prim_iter_math.sv
// Iterative floor/ceil divide, clog2 and vbits on runtime operands with a valid/ready handshake.
// Define PRIM_ITER_MATH_EARLY_EXIT_EN to skip the dividend's leading zeros in the divide loop.
module prim_iter_math
  import prim_iter_math_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] result_o,
  output logic [Width-1:0] rem_o,
  output logic             err_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [Width-1:0] quo_q, quo_d;    // dividend/quotient shifter, or the log value v
  logic [Width:0]   prem_q, prem_d;  // partial remainder
  logic [Width-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;    // iterations left (DIV) or bit count (LOG)
  logic             a_one_q, a_one_d;
  logic [Width-1:0] result_q, result_d;
  logic [Width-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic [CntW-1:0]  iter_init;
  logic [Width-1:0] a_aligned;
  logic [Width:0]   trial;
  logic             trial_ge;

`ifdef PRIM_ITER_MATH_EARLY_EXIT_EN
  logic [CntW-1:0] lz_cnt;

  prim_iter_math_lzc #(
    .Width (Width)
  ) u_lzc (
    .a_i      (a_i),
    .lz_cnt_o (lz_cnt)
  );

  assign iter_init = CntW'(Width) - lz_cnt;
  assign a_aligned = a_i << lz_cnt;
`else
  assign iter_init = CntW'(Width);
  assign a_aligned = a_i;
`endif

  assign trial    = {prem_q[Width-1:0], quo_q[Width-1]};
  assign trial_ge = (trial >= {1'b0, dvs_q});

  // NOTE: every variable is given a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quo_d    = quo_q;
    prem_d   = prem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    a_one_d  = a_one_q;
    result_d = result_q;
    rem_d    = rem_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d    = op_e'(op_i);
          dvs_d   = b_i;
          prem_d  = '0;
          a_one_d = (a_i == Width'(1));
          if (is_div_op(op_e'(op_i))) begin
            if (b_i == '0) begin
              result_d = '1;
              rem_d    = a_i;
              err_d    = 1'b1;
              state_d  = StDone;
            end else begin
              quo_d   = a_aligned;
              cnt_d   = iter_init;
              state_d = (iter_init == '0) ? StFix : StDiv;
            end
          end else begin
            quo_d   = (a_i == '0) ? '0 : a_i - Width'(1);
            cnt_d   = '0;
            state_d = StLog;
          end
        end
      end

      StDiv: begin
        prem_d = trial_ge ? (trial - {1'b0, dvs_q}) : trial;
        quo_d  = {quo_q[Width-2:0], trial_ge};
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end

      // A nonzero remainder implies divisor > 1, so the increment cannot wrap.
      StFix: begin
        result_d = quo_q + Width'(op_q == OpCeilDiv && prem_q != '0);
        rem_d    = prem_q[Width-1:0];
        err_d    = 1'b0;
        state_d  = StDone;
      end

      StLog: begin
        if (quo_q != '0) begin
          quo_d = quo_q >> 1;
          cnt_d = cnt_q + CntW'(1);
        end else begin
          result_d = (op_q == OpVbits && a_one_q) ? Width'(1) : Width'(cnt_q);
          rem_d    = '0;
          err_d    = 1'b0;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (rsp_ready_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      quo_q    <= '0;
      prem_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      a_one_q  <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      prem_q   <= prem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      a_one_q  <= a_one_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign rem_o       = rem_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prim_iter_math.sv
// Self-checking bench for prim_iter_math: directed and random requests against an arithmetic model.
module tb_prim_iter_math;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] result_o;
  logic [W-1:0] rem_o;
  logic         err_o;

  prim_iter_math #(.Width(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .result_o    (result_o),
    .rem_o       (rem_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   force_low = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_iters(input logic [W-1:0] a);
    int n = 0;
    for (int i = 0; i < W; i++) if (a[i]) n = i + 1;
`ifndef PRIM_ITER_MATH_EARLY_EXIT_EN
    n = W;
`endif
    return n;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   c;
    longint unsigned av;
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.err = 1'b0;
    e.acc = 0;
    av    = longint'(a);
    if (op < 2'd2) begin
      if (b == '0) begin
        e.res = '1;
        e.rem = a;
        e.err = 1'b1;
        e.lat = 1;
      end else begin
        e.res = a / b;
        e.rem = a % b;
        if (op == 2'd1 && e.rem != '0) e.res = e.res + 1'b1;
        e.lat = div_iters(a) + 2;
      end
    end else begin
      c = 0;
      while ((longint'(1) << c) < av) c++;
      e.res = W'(c);
      if (op == 2'd3 && a == W'(1)) e.res = W'(1);
      e.rem = '0;
      e.lat = c + 2;
    end
    return e;
  endfunction

  // Response ready: random unless the bench is holding it low.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready_i = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Compare process: checks reset values, idle behaviour, responses, latency and hold stability.
  exp_t         cur;
  bit           in_rsp = 1'b0;
  logic [W-1:0] h_res, h_rem;
  logic         h_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 1'b0;
      check("rst_result", result_o, '0);
      check("rst_rem", rem_o, '0);
      check("rst_err", err_o, 1'b0);
      check("rst_rsp_valid", rsp_valid_o, 1'b0);
      check("rst_req_ready", req_ready_o, 1'b1);
    end else begin
      check("req_ready", req_ready_o, exp_q.size() == 0);
      if (exp_q.size() == 0) begin
        check("rsp_valid_idle", rsp_valid_o, 1'b0);
      end else begin
        cur = exp_q[0];
        if (rsp_valid_o) begin
          if (!in_rsp) begin
            check($sformatf("result op%0d a=%0h b=%0h", cur.op, cur.a, cur.b), result_o, cur.res);
            check($sformatf("rem op%0d a=%0h b=%0h", cur.op, cur.a, cur.b), rem_o, cur.rem);
            check($sformatf("err op%0d a=%0h b=%0h", cur.op, cur.a, cur.b), err_o, cur.err);
            check($sformatf("latency op%0d a=%0h b=%0h", cur.op, cur.a, cur.b),
                  cyc - cur.acc + 1, cur.lat);
            h_res  = result_o;
            h_rem  = rem_o;
            h_err  = err_o;
            in_rsp = 1'b1;
          end else begin
            check("hold_result", result_o, h_res);
            check("hold_rem", rem_o, h_rem);
            check("hold_err", err_o, h_err);
          end
          if (rsp_ready_i) begin
            void'(exp_q.pop_front());
            in_rsp = 1'b0;
          end
        end else if (cyc - cur.acc > 100) begin
          check("rsp_timeout", rsp_valid_o, 1'b1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Inputs change #1 after a posedge; the following posedge is the accept edge once ready.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   t = 0;
    op_i        = op;
    a_i         = a;
    b_i         = b;
    req_valid_i = 1'b1;
    while (!req_ready_o && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", req_ready_o, 1'b1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e     = model(op, a, b);
    e.acc = cyc;
    exp_q.push_back(e);
    req_valid_i = 1'b0;
    op_i        = 2'($urandom);
    a_i         = W'($urandom);
    b_i         = W'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  exp_t m;

  initial begin
    int t;
    rst_n       = 1'b1;
    req_valid_i = 1'b0;
    op_i        = '0;
    a_i         = '0;
    b_i         = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed pins on the model itself.
    m = model(2'd0, W'(100), W'(7));
    check("pin_div_q", m.res, 14);
    check("pin_div_r", m.rem, 2);
`ifdef PRIM_ITER_MATH_EARLY_EXIT_EN
    check("pin_div_lat", m.lat, 9);
    m = model(2'd0, W'(5), W'(1));
    check("pin_ee_lat", m.lat, 5);
`else
    check("pin_div_lat", m.lat, 18);
`endif
    m = model(2'd1, W'(15), W'(6));
    check("pin_ceil_q", m.res, 3);
    check("pin_ceil_r", m.rem, 3);
    m = model(2'd2, W'(65), '0);
    check("pin_clog2_65", m.res, 7);
    check("pin_clog2_65_lat", m.lat, 9);
    m = model(2'd3, W'(1), '0);
    check("pin_vbits_1", m.res, 1);
    m = model(2'd0, W'(9), '0);
    check("pin_div0_res", m.res, 16'hFFFF);
    check("pin_div0_lat", m.lat, 1);

    // Directed arithmetic cases.
    send(2'd0, W'(100), W'(7));
    send(2'd1, W'(10), W'(3));
    send(2'd1, W'(12), W'(4));
    send(2'd1, W'(15), W'(6));
    send(2'd0, 16'hFFFF, W'(1));
    send(2'd2, W'(0), '0);
    send(2'd2, W'(1), '0);
    send(2'd2, W'(64), '0);
    send(2'd2, W'(65), '0);
    send(2'd2, 16'hFFFF, '0);
    send(2'd3, W'(1), '0);
    send(2'd3, W'(64), '0);
    send(2'd0, W'(9), '0);
    send(2'd0, W'(20), W'(5));
    send(2'd0, W'(5), W'(1));
    send(2'd1, '0, W'(3));
    wait_idle();

    // Hold the response for 5 cycles, then issue back-to-back requests.
    force_low = 1'b1;
    send(2'd1, W'(50), W'(3));
    t = 0;
    while (!rsp_valid_o && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("hold_rsp_seen", rsp_valid_o, 1'b1);
    repeat (5) @(posedge clk);
    #1 force_low = 1'b0;
    send(2'd0, W'(1234), W'(10));
    send(2'd3, W'(300), '0);
    send(2'd0, W'(77), '0);
    wait_idle();

    // Abort a divide with reset during its fifth DIV cycle; no response may follow.
    send(2'd0, W'(1000), W'(3));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 6) @(posedge clk);
    #1;

    // Random traffic across all ops and operand magnitudes.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = W'($urandom) & W'((32'd1 << $urandom_range(0, W)) - 1);
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'(1);
        2:       b = W'($urandom_range(2, 15));
        default: b = W'($urandom) & W'((32'd1 << $urandom_range(1, W)) - 1);
      endcase
      send(op, a, b);
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
